// File: rtl/arch_map_table_gen_if.sv
// Signal bundle between the ActiveList/RMT/free list side (master) and the architectural map table (slave).
interface arch_map_table_gen_if #(
  parameter int COMMIT_WIDTH = 4,
  parameter int LOG_W        = 5,
  parameter int PHYS_W       = 7,
  parameter int RCV_WIDTH    = 4
);
  logic [COMMIT_WIDTH-1:0]        commit_valid_i;
  logic [COMMIT_WIDTH*LOG_W-1:0]  commit_log_i;
  logic [COMMIT_WIDTH*PHYS_W-1:0] commit_phys_i;
  logic [COMMIT_WIDTH-1:0]        rel_valid_o;
  logic [COMMIT_WIDTH*PHYS_W-1:0] rel_phys_o;
  logic                           recover_req_i;
  logic                           recover_busy_o;
  logic                           rcv_valid_o;
  logic [RCV_WIDTH*LOG_W-1:0]     rcv_log_o;
  logic [RCV_WIDTH*PHYS_W-1:0]    rcv_phys_o;
  logic                           recover_done_o;

  modport master (
    output commit_valid_i, commit_log_i, commit_phys_i, recover_req_i,
    input  rel_valid_o, rel_phys_o, recover_busy_o, rcv_valid_o,
    input  rcv_log_o, rcv_phys_o, recover_done_o
  );

  modport slave (
    input  commit_valid_i, commit_log_i, commit_phys_i, recover_req_i,
    output rel_valid_o, rel_phys_o, recover_busy_o, rcv_valid_o,
    output rcv_log_o, rcv_phys_o, recover_done_o
  );
endinterface

// File: rtl/arch_map_table_gen.sv
// Architectural map table: committed logical->physical mappings, displaced-tag release,
// and a recovery walk that streams the whole table to the RMT RCV_WIDTH entries per beat.
module arch_map_table_gen #(
  parameter int COMMIT_WIDTH = 4,
  parameter int NUM_LOG      = 32,
  parameter int LOG_W        = 5,
  parameter int PHYS_W       = 7,
  parameter int RCV_WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  arch_map_table_gen_if.slave  bus
);

  localparam logic [LOG_W-1:0] LAST_CNT = LOG_W'(NUM_LOG - RCV_WIDTH);
  localparam logic [LOG_W-1:0] CNT_STEP = LOG_W'(RCV_WIDTH);

  if ((NUM_LOG % RCV_WIDTH) != 0) begin : g_bad_rcv_width
    $error("arch_map_table_gen: NUM_LOG must be a multiple of RCV_WIDTH");
  end

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WALK = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [LOG_W-1:0]        cnt_q, cnt_d;
  logic [PHYS_W-1:0]       table_q [NUM_LOG];
  logic [COMMIT_WIDTH-1:0] superseded;
  logic [LOG_W-1:0]        lane_idx;

  // A slot loses to any younger valid slot writing the same logical register.
  always_comb begin
    superseded = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      for (int j = k + 1; j < COMMIT_WIDTH; j++) begin
        if (bus.commit_valid_i[k] && bus.commit_valid_i[j] &&
            (bus.commit_log_i[k*LOG_W +: LOG_W] == bus.commit_log_i[j*LOG_W +: LOG_W])) begin
          superseded[k] = 1'b1;
        end else begin
          superseded[k] = superseded[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LOG; i++) begin
        table_q[i] <= PHYS_W'(i);
      end
    end else if (state_q == ST_IDLE) begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (bus.commit_valid_i[k] && !superseded[k]) begin
          table_q[bus.commit_log_i[k*LOG_W +: LOG_W]] <= bus.commit_phys_i[k*PHYS_W +: PHYS_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.recover_req_i) begin
          state_d = ST_WALK;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WALK: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_STEP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Release reads the pre-update table; everything reads zero while reset is held.
  always_comb begin
    bus.rel_valid_o    = '0;
    bus.rel_phys_o     = '0;
    bus.recover_busy_o = 1'b0;
    bus.rcv_valid_o    = 1'b0;
    bus.rcv_log_o      = '0;
    bus.rcv_phys_o     = '0;
    bus.recover_done_o = 1'b0;
    lane_idx           = '0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (bus.commit_valid_i[k]) begin
              bus.rel_valid_o[k] = 1'b1;
              bus.rel_phys_o[k*PHYS_W +: PHYS_W] = superseded[k] ?
                  bus.commit_phys_i[k*PHYS_W +: PHYS_W] :
                  table_q[bus.commit_log_i[k*LOG_W +: LOG_W]];
            end else begin
              bus.rel_valid_o[k] = 1'b0;
            end
          end
        end
        ST_WALK: begin
          bus.recover_busy_o = 1'b1;
          bus.rcv_valid_o    = 1'b1;
          bus.recover_done_o = (cnt_q == LAST_CNT);
          for (int m = 0; m < RCV_WIDTH; m++) begin
            lane_idx = cnt_q + LOG_W'(m);
            bus.rcv_log_o[m*LOG_W +: LOG_W]   = lane_idx;
            bus.rcv_phys_o[m*PHYS_W +: PHYS_W] = table_q[lane_idx];
          end
        end
        default: begin
          bus.recover_busy_o = 1'b0;
        end
      endcase
    end else begin
      bus.recover_busy_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_arch_map_table_gen.sv
// Self-checking bench: directed scenarios plus random commit/recover traffic against a table model.
module tb_arch_map_table_gen;
  localparam int CW = 4, NL = 32, LW = 5, PW = 7, RW = 4, BEATS = NL / RW;
  localparam int CW2 = 2, NL2 = 64, LW2 = 6, PW2 = 7, RW2 = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  int   checks = 0;
  int   failures = 0;

  int   tbl [NL];
  bit   walking = 1'b0;
  int   beat = 0;
  logic [CW-1:0]    cur_v;
  logic [CW*LW-1:0] cur_lg;
  logic [CW*PW-1:0] cur_ph;
  logic             cur_req, cur_rst;

  always #5 clk = ~clk;

  arch_map_table_gen_if #(.COMMIT_WIDTH(CW), .LOG_W(LW), .PHYS_W(PW), .RCV_WIDTH(RW)) bus ();
  arch_map_table_gen_if #(.COMMIT_WIDTH(CW2), .LOG_W(LW2), .PHYS_W(PW2), .RCV_WIDTH(RW2)) bus2 ();

  arch_map_table_gen #(.COMMIT_WIDTH(CW), .NUM_LOG(NL), .LOG_W(LW), .PHYS_W(PW), .RCV_WIDTH(RW))
    dut (.clk(clk), .reset(reset), .bus(bus));
  arch_map_table_gen #(.COMMIT_WIDTH(CW2), .NUM_LOG(NL2), .LOG_W(LW2), .PHYS_W(PW2), .RCV_WIDTH(RW2))
    dut2 (.clk(clk), .reset(reset2), .bus(bus2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge and compare outputs with the model's prediction.
  task automatic drive(input logic [CW-1:0] v, input logic [CW*LW-1:0] lg,
                       input logic [CW*PW-1:0] ph, input logic req, input logic rst);
    logic [CW-1:0]    e_rv;
    logic [CW*PW-1:0] e_rp;
    logic [RW*LW-1:0] e_rl;
    logic [RW*PW-1:0] e_rcp;
    logic             e_busy, e_done;
    bit               younger;
    @(negedge clk);
    bus.commit_valid_i = v;   bus.commit_log_i = lg;  bus.commit_phys_i = ph;
    bus.recover_req_i  = req; reset = rst;
    cur_v = v; cur_lg = lg; cur_ph = ph; cur_req = req; cur_rst = rst;
    #1;
    e_rv = '0; e_rp = '0; e_rl = '0; e_rcp = '0; e_busy = 1'b0; e_done = 1'b0;
    if (!rst && !walking) begin
      for (int k = 0; k < CW; k++) begin
        if (v[k]) begin
          younger = 1'b0;
          for (int j = k + 1; j < CW; j++)
            if (v[j] && lg[j*LW +: LW] == lg[k*LW +: LW]) younger = 1'b1;
          e_rv[k] = 1'b1;
          e_rp[k*PW +: PW] = younger ? ph[k*PW +: PW] : PW'(tbl[lg[k*LW +: LW]]);
        end
      end
    end else if (!rst) begin
      e_busy = 1'b1;
      e_done = (beat == BEATS - 1);
      for (int m = 0; m < RW; m++) begin
        e_rl[m*LW +: LW]  = LW'(beat * RW + m);
        e_rcp[m*PW +: PW] = PW'(tbl[beat * RW + m]);
      end
    end
    chk("rel_valid", bus.rel_valid_o, e_rv);
    chk("rel_phys", bus.rel_phys_o, e_rp);
    chk("busy", bus.recover_busy_o, e_busy);
    chk("rcv_valid", bus.rcv_valid_o, e_busy);
    chk("rcv_log", bus.rcv_log_o, e_rl);
    chk("rcv_phys", bus.rcv_phys_o, e_rcp);
    chk("done", bus.recover_done_o, e_done);
  endtask

  task automatic tick();
    @(posedge clk);
    if (cur_rst) begin
      for (int i = 0; i < NL; i++) tbl[i] = i;
      walking = 1'b0;
      beat = 0;
    end else if (!walking) begin
      for (int k = 0; k < CW; k++)
        if (cur_v[k]) tbl[cur_lg[k*LW +: LW]] = int'(cur_ph[k*PW +: PW]);
      if (cur_req) begin
        walking = 1'b1;
        beat = 0;
      end
    end else begin
      beat++;
      if (beat == BEATS) begin
        walking = 1'b0;
        beat = 0;
      end
    end
  endtask

  task automatic step(input logic [CW-1:0] v, input logic [CW*LW-1:0] lg,
                      input logic [CW*PW-1:0] ph, input logic req, input logic rst);
    drive(v, lg, ph, req, rst);
    tick();
  endtask

  initial begin
    logic [CW*LW-1:0] lg_t2;
    logic [CW*PW-1:0] ph_t2;
    lg_t2 = {5'd3, 5'd3, 5'd5, 5'd3};
    ph_t2 = {7'd43, 7'd42, 7'd41, 7'd40};
    bus.commit_valid_i = '0; bus.commit_log_i = '0; bus.commit_phys_i = '0; bus.recover_req_i = 1'b0;
    bus2.commit_valid_i = '0; bus2.commit_log_i = '0; bus2.commit_phys_i = '0; bus2.recover_req_i = 1'b0;

    step('0, '0, '0, 1'b1, 1'b1);
    step('0, '0, '0, 1'b0, 1'b1);

    // T1: identity walk
    step('0, '0, '0, 1'b1, 1'b0);
    for (int b = 0; b < BEATS; b++) step('0, '0, '0, 1'b0, 1'b0);
    step('0, '0, '0, 1'b0, 1'b0);

    // T2: full-width commit with repeated destination
    drive(4'b1111, lg_t2, ph_t2, 1'b0, 1'b0);
    chk("t2_rel_phys", bus.rel_phys_o, {7'd3, 7'd42, 7'd5, 7'd40});
    chk("t2_rel_valid", bus.rel_valid_o, 4'b1111);
    tick();
    step('0, '0, '0, 1'b1, 1'b0);
    for (int b = 0; b < BEATS; b++) step('0, '0, '0, 1'b0, 1'b0);

    // T3: slots 1 and 3 only
    step('0, '0, '0, 1'b0, 1'b1);
    drive(4'b1010, lg_t2, ph_t2, 1'b0, 1'b0);
    chk("t3_rel_phys", bus.rel_phys_o, {7'd3, 7'd0, 7'd5, 7'd0});
    chk("t3_rel_valid", bus.rel_valid_o, 4'b1010);
    tick();

    // T4: commit alongside the recover request, then commits ignored during the walk
    step(4'b0001, 20'd7, 28'd50, 1'b1, 1'b0);
    step(4'b1111, 20'($urandom), 28'($urandom), 1'b1, 1'b0);
    drive(4'b1111, 20'($urandom), 28'($urandom), 1'b0, 1'b0);
    chk("t4_lane3_log", bus.rcv_log_o[3*LW +: LW], 64'd7);
    chk("t4_lane3_phys", bus.rcv_phys_o[3*PW +: PW], 64'd50);
    tick();
    for (int b = 2; b < BEATS; b++) step(4'b1111, 20'($urandom), 28'($urandom), 1'b0, 1'b0);
    step('0, '0, '0, 1'b1, 1'b0);
    for (int b = 0; b < BEATS; b++) step('0, '0, '0, 1'b0, 1'b0);

    // T5: reset in the middle of a walk
    step('0, '0, '0, 1'b1, 1'b0);
    for (int b = 0; b < 3; b++) step('0, '0, '0, 1'b0, 1'b0);
    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b0);
    step('0, '0, '0, 1'b1, 1'b0);
    for (int b = 0; b < BEATS; b++) step('0, '0, '0, 1'b0, 1'b0);

    // Random traffic; even iterations force destination collisions
    for (int it = 0; it < 400; it++) begin
      logic [CW*LW-1:0] lg;
      for (int k = 0; k < CW; k++)
        lg[k*LW +: LW] = (it % 2 == 0) ? LW'($urandom_range(0, 3)) : LW'($urandom);
      step(CW'($urandom), lg, 28'($urandom), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 63) == 0));
    end

    // T6: 2-wide commit, 64 entries, 8 lanes per beat
    @(negedge clk);
    reset2 = 1'b0;
    bus2.commit_valid_i = 2'b11;
    bus2.commit_log_i   = {6'd9, 6'd9};
    bus2.commit_phys_i  = {7'd101, 7'd100};
    #1;
    chk("t6_rel_valid", bus2.rel_valid_o, 2'b11);
    chk("t6_rel_phys", bus2.rel_phys_o, {7'd9, 7'd100});
    @(negedge clk);
    bus2.commit_valid_i = '0;
    bus2.recover_req_i  = 1'b1;
    #1;
    chk("t6_idle_busy", bus2.recover_busy_o, 1'b0);
    @(negedge clk);
    bus2.recover_req_i = 1'b0;
    for (int b = 0; b < NL2 / RW2; b++) begin
      #1;
      chk("t6_busy", bus2.recover_busy_o, 1'b1);
      chk("t6_done", bus2.recover_done_o, (b == NL2 / RW2 - 1));
      chk("t6_lane0_log", bus2.rcv_log_o[0 +: LW2], 64'(b * RW2));
      if (b == 1) chk("t6_lane1_phys", bus2.rcv_phys_o[PW2 +: PW2], 64'd101);
      @(negedge clk);
    end
    #1;
    chk("t6_end_busy", bus2.recover_busy_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
